// File: rtl/block_mult_pkg.sv
// Shared types, defaults and helpers for the block multiply-accumulate engine.
package block_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_ACK     = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_DIM        = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Saturation works on a fixed wide container: enough for DW<=64, DIM<=8.
  localparam int unsigned MAX_DW = 64;
  localparam int unsigned SAT_W  = 2*MAX_DW + 4;

  function automatic int unsigned elem_lsb(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned dim,
                                           input int unsigned dw);
    return (row*dim + col)*dw;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] value,
                                                     input int unsigned dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = signed'((SAT_W'(1) << (dw - 1)) - SAT_W'(1));
    lo = ~hi;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/dot_product_unit.sv
// Combinational signed dot product of one A row and one B column, full-width sum.
module dot_product_unit
  import block_mult_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DIM        = DEFAULT_DIM
) (
  input  logic        [DIM*DATA_WIDTH-1:0]                row,
  input  logic        [DIM*DATA_WIDTH-1:0]                col,
  output logic signed [2*DATA_WIDTH+$clog2(DIM)-1:0]      dot
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned DOT_W = 2*DW + $clog2(DIM);

  logic signed [DW-1:0]    a_e;
  logic signed [DW-1:0]    b_e;
  logic signed [2*DW-1:0]  prod;
  logic signed [DOT_W-1:0] acc;

  always_comb begin
    acc  = '0;
    a_e  = '0;
    b_e  = '0;
    prod = '0;
    for (int unsigned k = 0; k < DIM; k++) begin
      a_e  = signed'(row[k*DW +: DW]);
      b_e  = signed'(col[k*DW +: DW]);
      prod = a_e * b_e;
      acc  = acc + DOT_W'(prod);
    end
    dot = acc;
  end

endmodule

// File: rtl/block_mult_4x4.sv
// Block multiply-accumulate engine: C += A*B, one C element per cycle, stb/ack handshake.
// Optional BLOCK_MULT_SATURATE_EN: clamp write-back to signed DW range, sticky overflow flag.
module block_mult_4x4
  import block_mult_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DIM        = DEFAULT_DIM
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           a_stb,
  input  logic                           b_stb,
  input  logic [DIM*DIM*DATA_WIDTH-1:0]  a_block,
  input  logic [DIM*DIM*DATA_WIDTH-1:0]  b_block,
  input  logic                           c_clear,
  output logic                           a_ack,
  output logic                           b_ack,
  output logic                           busy,
  output logic [DIM*DIM*DATA_WIDTH-1:0]  c_block
`ifdef BLOCK_MULT_SATURATE_EN
  ,
  output logic                           overflow
`endif
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned BLK_W = DIM*DIM*DW;
  localparam int unsigned ROW_W = DIM*DW;
  localparam int unsigned DOT_W = 2*DW + $clog2(DIM);
  localparam int unsigned SUM_W = DOT_W + 1;
  localparam int unsigned IDX_W = $clog2(DIM*DIM);
  localparam int unsigned LAST  = DIM*DIM - 1;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [BLK_W-1:0]        a_lat;
  logic [BLK_W-1:0]        b_lat;
  logic [BLK_W-1:0]        c_reg;
  logic                    ack;
  logic                    busy_q;

  int unsigned             row_i;
  int unsigned             col_j;
  int unsigned             c_off;
  logic [ROW_W-1:0]        row_op;
  logic [ROW_W-1:0]        col_op;
  logic signed [DOT_W-1:0] dot;
  logic [DW-1:0]           c_old;
  logic signed [SUM_W-1:0] sum_wide;
  logic [DW-1:0]           c_new;

`ifdef BLOCK_MULT_SATURATE_EN
  logic                    ovf_q;
  logic                    ovf_hit;
  logic signed [SAT_W-1:0] sum_ext;
  logic signed [SAT_W-1:0] sat_val;
`endif

  // Single shared lane set: row of A and column of B selected by idx.
  always_comb begin
    row_i  = 32'(idx) / DIM;
    col_j  = 32'(idx) % DIM;
    c_off  = elem_lsb(row_i, col_j, DIM, DW);
    row_op = a_lat[row_i*ROW_W +: ROW_W];
    col_op = '0;
    for (int unsigned k = 0; k < DIM; k++) begin
      col_op[k*DW +: DW] = b_lat[elem_lsb(k, col_j, DIM, DW) +: DW];
    end
  end

  dot_product_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIM        (DIM)
  ) u_dot (
    .row (row_op),
    .col (col_op),
    .dot (dot)
  );

  always_comb begin
    c_old    = c_reg[c_off +: DW];
    sum_wide = SUM_W'(dot) + SUM_W'(signed'(c_old));
`ifdef BLOCK_MULT_SATURATE_EN
    sum_ext  = SAT_W'(sum_wide);
    sat_val  = sat_dw(sum_ext, DW);
    ovf_hit  = (sat_val != sum_ext);
    c_new    = sat_val[DW-1:0];
`else
    c_new    = sum_wide[DW-1:0];
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
      c_reg  <= '0;
      ack    <= 1'b0;
      busy_q <= 1'b0;
`ifdef BLOCK_MULT_SATURATE_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (c_clear) begin
            c_reg <= '0;
`ifdef BLOCK_MULT_SATURATE_EN
            ovf_q <= 1'b0;
`endif
          end
          if (a_stb && b_stb) begin
            a_lat  <= a_block;
            b_lat  <= b_block;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          c_reg[c_off +: DW] <= c_new;
`ifdef BLOCK_MULT_SATURATE_EN
          ovf_q <= ovf_q | ovf_hit;
`endif
          idx <= idx + 1'b1;
          if (idx == IDX_W'(LAST)) begin
            ack    <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_ACK;
          end
        end
        S_ACK: begin
          if (!a_stb && !b_stb) begin
            ack   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          ack    <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign a_ack   = ack;
  assign b_ack   = ack;
  assign busy    = busy_q;
  assign c_block = c_reg;
`ifdef BLOCK_MULT_SATURATE_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_block_mult_4x4.sv
// Scoreboard bench for block_mult_4x4: directed blocks, monitor checks C and ack latency on each ack.
module tb_block_mult_4x4;

  localparam int unsigned DW  = 32;
  localparam int unsigned DIM = 4;
  localparam int unsigned BW  = DIM*DIM*DW;

  typedef logic [BW-1:0] blk_t;
  typedef struct {
    blk_t        c;
    int unsigned cyc;
    int unsigned tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic a_stb = 1'b0;
  logic b_stb = 1'b0;
  logic c_clear = 1'b0;
  blk_t a_block = '0;
  blk_t b_block = '0;
  logic a_ack;
  logic b_ack;
  logic busy;
  blk_t c_block;
`ifdef BLOCK_MULT_SATURATE_EN
  logic overflow;
`endif

  exp_t        sb[$];
  exp_t        cur;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          busy_run = 0;
  logic        prev_ack = 1'b0;

  block_mult_4x4 #(
    .DATA_WIDTH (DW),
    .DIM        (DIM)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .a_stb   (a_stb),
    .b_stb   (b_stb),
    .a_block (a_block),
    .b_block (b_block),
    .c_clear (c_clear),
    .a_ack   (a_ack),
    .b_ack   (b_ack),
    .busy    (busy),
    .c_block (c_block)
`ifdef BLOCK_MULT_SATURATE_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input blk_t act, input blk_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic blk_t splat(input logic [DW-1:0] v);
    blk_t b;
    b = '0;
    for (int i = 0; i < DIM*DIM; i++) b[i*DW +: DW] = v;
    return b;
  endfunction

  // 0: identity, 1: k*4+j, 2: row 0 = 5, 3: column index j, 4: 4+j
  function automatic blk_t pattern(input int unsigned kind);
    blk_t b;
    b = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        case (kind)
          0:       b[(r*DIM+c)*DW +: DW] = (r == c) ? DW'(1) : DW'(0);
          1:       b[(r*DIM+c)*DW +: DW] = DW'(r*4 + c);
          2:       b[(r*DIM+c)*DW +: DW] = (r == 0) ? DW'(5) : DW'(0);
          3:       b[(r*DIM+c)*DW +: DW] = DW'(c);
          default: b[(r*DIM+c)*DW +: DW] = DW'(4 + c);
        endcase
      end
    end
    return b;
  endfunction

  // Monitor: on each ack rise, pop and compare result, latency and busy length.
  always @(negedge clock) begin
    if (!reset) begin
      busy_run = 0;
      prev_ack = 1'b0;
    end else begin
      if (busy) busy_run++;
      if (a_ack && !prev_ack) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: got ack at cycle %0d required no ack", cyc);
        end else begin
          cur = sb.pop_front();
          check($sformatf("c_block#%0d", cur.tag), c_block, cur.c);
          check($sformatf("ack_cycle#%0d", cur.tag), blk_t'(cyc), blk_t'(cur.cyc));
          check($sformatf("busy_len#%0d", cur.tag), blk_t'(busy_run), blk_t'(DIM*DIM));
          check($sformatf("b_ack#%0d", cur.tag), blk_t'(b_ack), blk_t'(1));
        end
        busy_run = 0;
      end
      prev_ack = a_ack;
    end
  end

  task automatic wait_ack();
    int n;
    n = 0;
    while (!a_ack && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (!a_ack) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: got no ack after %0d cycles required ack", n);
    end
  endtask

  task automatic run_block(input blk_t a, input blk_t b, input logic clr,
                           input blk_t expc, input int unsigned tag);
    @(negedge clock);
    a_block = a;
    b_block = b;
    a_stb   = 1'b1;
    b_stb   = 1'b1;
    c_clear = clr;
    sb.push_back('{c: expc, cyc: cyc + 1 + DIM*DIM, tag: tag});
    @(negedge clock);
    c_clear = 1'b0;
    wait_ack();
    a_stb = 1'b0;
    b_stb = 1'b0;
    @(negedge clock);
    check($sformatf("ack_drop#%0d", tag), blk_t'(a_ack), blk_t'(0));
  endtask

  initial begin
    logic seen;

    repeat (2) @(negedge clock);
    check("reset_c", c_block, '0);
    check("reset_ack", blk_t'({a_ack, b_ack}), blk_t'(0));
    check("reset_busy", blk_t'(busy), blk_t'(0));
    reset = 1'b1;

    // Identity, accumulate, clear coincident with capture
    run_block(pattern(0), pattern(1), 1'b1, pattern(1), 1);
    run_block(splat(1), splat(2), 1'b1, splat(8), 2);
    run_block(splat(1), splat(2), 1'b0, splat(16), 3);
    run_block(splat(1), pattern(2), 1'b1, splat(5), 4);
    run_block(splat(1), splat(1), 1'b1, splat(4), 5);

    // Single strobe must not capture
    @(negedge clock);
    a_block = pattern(0);
    a_stb   = 1'b1;
    seen    = 1'b0;
    repeat (10) begin
      @(negedge clock);
      seen = seen | busy | a_ack;
    end
    check("single_strobe", blk_t'(seen), blk_t'(0));
    b_block = pattern(3);
    b_stb   = 1'b1;
    sb.push_back('{c: pattern(4), cyc: cyc + 1 + DIM*DIM, tag: 6});
    @(negedge clock);
    wait_ack();
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      seen = seen | ~a_ack;
    end
    check("ack_hold", blk_t'(seen), blk_t'(0));
    a_stb = 1'b0;
    b_stb = 1'b0;
    @(negedge clock);
    check("ack_release", blk_t'(a_ack), blk_t'(0));

    // Overflow
`ifdef BLOCK_MULT_SATURATE_EN
    run_block(splat(32'h7FFF_FFFF), splat(2), 1'b1, splat(32'h7FFF_FFFF), 7);
    check("ovf_set", blk_t'(overflow), blk_t'(1));
    @(negedge clock);
    c_clear = 1'b1;
    @(negedge clock);
    c_clear = 1'b0;
    check("ovf_clear", blk_t'(overflow), blk_t'(0));
    check("c_cleared", c_block, '0);
`else
    run_block(splat(32'h7FFF_FFFF), splat(2), 1'b1, splat(32'hFFFF_FFF8), 7);
`endif

    // Reset in the middle of compute
    @(negedge clock);
    a_block = splat(1);
    b_block = splat(2);
    a_stb   = 1'b1;
    b_stb   = 1'b1;
    @(posedge clock);
    repeat (7) @(posedge clock);
    #2;
    check("busy_mid", blk_t'(busy), blk_t'(1));
    reset = 1'b0;
    #1;
    check("rst_ack", blk_t'({a_ack, b_ack}), blk_t'(0));
    check("rst_busy", blk_t'(busy), blk_t'(0));
    check("rst_c", c_block, '0);
    a_stb = 1'b0;
    b_stb = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    run_block(splat(1), splat(2), 1'b0, splat(8), 8);

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clock);
    check("sb_drain", blk_t'(sb.size()), blk_t'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
